frame_overlay_mixer: RTL and testbench
======================================

# frame_overlay_mixer

Registered pixel compositor between `game_top` and the board's `red`/`green`/`blue` outputs in the graphics labs. It generalises the static one-pixel white play-field border into a parametrised rectangle with configurable thickness, blinking and a retriggerable hit-flash. Game sprites keep priority over the border. It also produces a once-per-frame tick for other frame-rate logic.

## Interface
- `screen_width`, 640: visible width in pixels
- `screen_height`, 480: visible height in pixels
- `w_x`, `$clog2(screen_width)`: x coordinate width
- `w_y`, `$clog2(screen_height)`: y coordinate width
- `w_red` / `w_green` / `w_blue`, 4 / 4 / 4: output colour widths
- `frame_left`, `screen_width/3`: first border column, inclusive
- `frame_right`, `screen_width*2/3`: last column + 1, exclusive
- `frame_top`, 1: first border row, inclusive
- `frame_bottom`, `screen_height-1`: last row + 1, exclusive
- `thickness`, 1: border width in pixels, ≥1
- `blink_frames`, 30: frames per blink half-period, ≥1
- `flash_frames`, 8: flash duration in frames, ≥1

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `display_on`  in  1  visible-area flag from the timing generator
- `x`  in  `w_x`  current pixel column
- `y`  in  `w_y`  current pixel row
- `game_rgb`  in  3  game colour {r,g,b}; 3'b000 = transparent
- `frame_en`  in  1  border enable
- `blink_en`  in  1  border blink enable
- `flash_req`  in  1  single-cycle pulse requesting a flash
- `red`  out  `w_red`  registered output colour
- `green`  out  `w_green`  registered output colour
- `blue`  out  `w_blue`  registered output colour
- `frame_tick`  out  1  one-cycle pulse at frame start
- `flashing`  out  1  high while the flash FSM is in FLASH

## Operation
- **Border hit.** A pixel is on the border when left ≤ x < right and top ≤ y < bottom, and it lies fewer than `thickness` pixels from any edge. All comparisons are unsigned and `w_x+1` / `w_y+1` bits wide, so `right-thickness` cannot wrap.
- **Frame tick.** Let `start` = (x==0 && y==0). `frame_tick` = `start` && !`start_q`, where `start_q` is `start` registered one cycle. This gives exactly one pulse per frame even when x/y advance slower than `clk`. `display_on` does not gate it.
- **Blink.** `blink_cnt` counts `frame_tick`s from 0 to `blink_frames-1`, then wraps to 0 and toggles `blink_vis`.
  - With `blink_en`=0, `blink_cnt` is held at 0 and `blink_vis` at 1.
- **Flash FSM**, states IDLE and FLASH.
  - IDLE → FLASH on `flash_req`; `flash_cnt` loads `flash_frames`.
  - In FLASH, each `frame_tick` decrements `flash_cnt`. A tick that finds `flash_cnt`==1 moves the FSM to IDLE.
  - `flash_req` in FLASH reloads `flash_cnt` (retrigger). If `flash_req` coincides with the final tick, `flash_req` wins: the FSM stays in FLASH with the count reloaded.
- **Border colour.** White in IDLE, full red in FLASH. The flash overrides blink: the border is visible during FLASH even when `blink_vis`=0.
- **Priority per pixel, highest first:**
  1. `display_on`=0 → black.
  2. `game_rgb`≠0 → each bit replicated across its channel width.
  3. Border hit && `frame_en` && (`blink_vis` || FLASH) → border colour.
  4. Otherwise black.

## Timing
- Colour latency is exactly 1 cycle: inputs sampled at edge n appear on `red`/`green`/`blue` after edge n.
- `frame_tick` is registered and asserts the cycle after the first `clk` edge that samples `start`=1.
- `flashing` changes the cycle after `flash_req` is sampled. The blink and flash counters update on the same edge that registers `frame_tick`.
- Reset values: `red`/`green`/`blue`=0, `frame_tick`=0, `flashing`=0.
  - Internal state: FSM=IDLE, `blink_cnt`=0, `blink_vis`=1, `flash_cnt`=0, `start_q`=1. `start_q`=1 suppresses a spurious tick when reset releases at (0,0).
- Reset mid-flash aborts to IDLE on the next edge.

## Structure
- Package `frame_overlay_pkg`:
  - `flash_state_t` enum {IDLE, FLASH}.
  - 3-bit colour constants `RGB_BLACK`, `RGB_WHITE`, `RGB_RED`.
- Sub-module `frame_border_hit`: purely combinational, parameterised by the rectangle and `thickness`. Inputs x, y; output `hit`. It is reusable for further overlay rectangles.
- The top level holds the tick detector, blink counter, flash FSM and output register.

## Test plan
- **Static border.** Defaults, `frame_en`=1, `blink_en`=0, `game_rgb`=0. Sweep one frame → white exactly at x∈{213,425}, y∈[1,479) and y∈{1,478}, x∈[213,426); black elsewhere; output 1 cycle after input.
- **Thickness.** `thickness`=3 → x=213..215 and 423..425 white, x=216 black, on row 100.
- **Blink.** `blink_frames`=2, drive 6 frame starts, each (0,0) held 2 cycles → exactly 6 `frame_tick`s; border visible, hidden, visible in frame pairs.
- **Flash retrigger.** `flash_frames`=3, `flash_req` at frame 0, again at frame 2 → `flashing` high for frames 0–4, red border, and red during a hidden blink phase.
- **Priority and blanking.**
  - `game_rgb`=3'b010 on a border pixel → {0,F,0}.
  - `display_on`=0 with `game_rgb`=3'b111 → black.
- **Reset.** Assert `rst` mid-flash → next cycle `flashing`=0 and colours 0. Releasing reset while x=y=0 → no `frame_tick`.

Source files
------------

// File: rtl/frame_overlay_pkg.sv
`default_nettype none
// ============================================================================
// frame_overlay_pkg: shared flash-state encoding and 3-bit colour constants.
// Revision: 1.0
// ============================================================================
package frame_overlay_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  localparam logic [2:0] RGB_BLACK = 3'b000;
  localparam logic [2:0] RGB_WHITE = 3'b111;
  localparam logic [2:0] RGB_RED   = 3'b100;

endpackage
`default_nettype wire

// File: rtl/frame_border_hit.sv
`default_nettype none
// ============================================================================
// frame_border_hit: combinational test for a pixel lying on a rectangle outline.
// Revision: 1.0
// ============================================================================
module frame_border_hit #(
  parameter int w_x       = 10,
  parameter int w_y       = 9,
  parameter int left      = 213,
  parameter int right     = 426,
  parameter int top       = 1,
  parameter int bottom    = 479,
  parameter int thickness = 1
) (
  input  logic [w_x-1:0] x,
  input  logic [w_y-1:0] y,
  output logic           hit
);

  localparam int XW = w_x + 1;
  localparam int YW = w_y + 1;

  // Inner edges are clamped at zero so an oversized thickness cannot wrap.
  localparam int RIGHT_IN_I  = (right  > thickness) ? right  - thickness : 0;
  localparam int BOTTOM_IN_I = (bottom > thickness) ? bottom - thickness : 0;

  localparam logic [XW-1:0] X_LEFT     = XW'(left);
  localparam logic [XW-1:0] X_RIGHT    = XW'(right);
  localparam logic [XW-1:0] X_LEFT_IN  = XW'(left + thickness);
  localparam logic [XW-1:0] X_RIGHT_IN = XW'(RIGHT_IN_I);
  localparam logic [YW-1:0] Y_TOP      = YW'(top);
  localparam logic [YW-1:0] Y_BOTTOM   = YW'(bottom);
  localparam logic [YW-1:0] Y_TOP_IN   = YW'(top + thickness);
  localparam logic [YW-1:0] Y_BOT_IN   = YW'(BOTTOM_IN_I);

  logic [XW-1:0] xe;
  logic [YW-1:0] ye;
  logic          in_rect;
  logic          near_edge;

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};

  assign in_rect   = (xe >= X_LEFT) && (xe < X_RIGHT) &&
                     (ye >= Y_TOP)  && (ye < Y_BOTTOM);
  assign near_edge = (xe < X_LEFT_IN) || (xe >= X_RIGHT_IN) ||
                     (ye < Y_TOP_IN)  || (ye >= Y_BOT_IN);
  assign hit       = in_rect && near_edge;

endmodule
`default_nettype wire

// File: rtl/frame_overlay_mixer.sv
`default_nettype none
// ============================================================================
// frame_overlay_mixer: registered compositor of game pixels over a blinking,
// flashable border, plus a once-per-frame tick.  Revision: 1.0
// ============================================================================
module frame_overlay_mixer
  import frame_overlay_pkg::*;
#(
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int w_red         = 4,
  parameter int w_green       = 4,
  parameter int w_blue        = 4,
  parameter int frame_left    = screen_width / 3,
  parameter int frame_right   = screen_width * 2 / 3,
  parameter int frame_top     = 1,
  parameter int frame_bottom  = screen_height - 1,
  parameter int thickness     = 1,
  parameter int blink_frames  = 30,
  parameter int flash_frames  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               display_on,
  input  logic [w_x-1:0]     x,
  input  logic [w_y-1:0]     y,
  input  logic [2:0]         game_rgb,
  input  logic               frame_en,
  input  logic               blink_en,
  input  logic               flash_req,
  output logic [w_red-1:0]   red,
  output logic [w_green-1:0] green,
  output logic [w_blue-1:0]  blue,
  output logic               frame_tick,
  output logic               flashing
);

  localparam int BLINK_W = (blink_frames > 1) ? $clog2(blink_frames) : 1;
  localparam int FLASH_W = $clog2(flash_frames + 1);

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(blink_frames - 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(flash_frames);

  logic               border_hit;
  logic               start_d,      start_q;
  logic               frame_tick_d, frame_tick_q;
  logic [BLINK_W-1:0] blink_cnt_d,  blink_cnt_q;
  logic               blink_vis_d,  blink_vis_q;
  flash_state_t       state_d,      state_q;
  logic [FLASH_W-1:0] flash_cnt_d,  flash_cnt_q;
  logic [2:0]         rgb_d,        rgb_q;

  frame_border_hit #(
    .w_x       (w_x),
    .w_y       (w_y),
    .left      (frame_left),
    .right     (frame_right),
    .top       (frame_top),
    .bottom    (frame_bottom),
    .thickness (thickness)
  ) u_border_hit (
    .x   (x),
    .y   (y),
    .hit (border_hit)
  );

  // Edge-detect the origin so a pixel clock slower than clk still ticks once.
  always_comb begin
    start_d      = (x == '0) && (y == '0);
    frame_tick_d = start_d && !start_q;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (frame_tick_d) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_vis_d = !blink_vis_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // A request always reloads, so it beats a coinciding final tick.
  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    case (state_q)
      IDLE: begin
        if (flash_req) begin
          state_d     = FLASH;
          flash_cnt_d = FLASH_LOAD;
        end
      end
      FLASH: begin
        if (flash_req) begin
          flash_cnt_d = FLASH_LOAD;
        end else if (frame_tick_d) begin
          if (flash_cnt_q == FLASH_W'(1)) begin
            state_d     = IDLE;
            flash_cnt_d = '0;
          end else begin
            flash_cnt_d = flash_cnt_q - FLASH_W'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        flash_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    rgb_d = RGB_BLACK;
    if (!display_on) begin
      rgb_d = RGB_BLACK;
    end else if (game_rgb != RGB_BLACK) begin
      rgb_d = game_rgb;
    end else if (border_hit && frame_en && (blink_vis_q || (state_q == FLASH))) begin
      rgb_d = (state_q == FLASH) ? RGB_RED : RGB_WHITE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q      <= 1'b1;
      frame_tick_q <= 1'b0;
      blink_cnt_q  <= '0;
      blink_vis_q  <= 1'b1;
      state_q      <= IDLE;
      flash_cnt_q  <= '0;
      rgb_q        <= RGB_BLACK;
    end else begin
      start_q      <= start_d;
      frame_tick_q <= frame_tick_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_vis_q  <= blink_vis_d;
      state_q      <= state_d;
      flash_cnt_q  <= flash_cnt_d;
      rgb_q        <= rgb_d;
    end
  end

  assign red        = {w_red{rgb_q[2]}};
  assign green      = {w_green{rgb_q[1]}};
  assign blue       = {w_blue{rgb_q[0]}};
  assign frame_tick = frame_tick_q;
  assign flashing   = (state_q == FLASH);

endmodule
`default_nettype wire

// File: tb/tb_frame_overlay_mixer.sv
`default_nettype none
// ============================================================================
// tb_frame_overlay_mixer: directed vectors and frame sequences for the mixer.
// Revision: 1.0
// ============================================================================
module tb_frame_overlay_mixer;

  localparam logic [2:0] K = 3'b000;
  localparam logic [2:0] W = 3'b111;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] M = 3'b101;

  typedef struct {
    logic       disp;
    logic [9:0] px;
    logic [8:0] py;
    logic [2:0] rgb;
    logic       fen;
    logic [2:0] exp_a;
    logic [2:0] exp_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       display_on = 1'b0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [2:0] game_rgb = '0;
  logic       frame_en = 1'b0;
  logic       blink_en = 1'b0;
  logic       flash_req = 1'b0;

  logic [3:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
  logic       frame_tick_a, flashing_a, frame_tick_b, flashing_b;

  int checks = 0;
  int errors = 0;
  int total_ticks = 0;

  vec_t vecs[19];

  always #5 clk = ~clk;

  // Instance A: thickness 1, short blink/flash periods for frame sequences.
  frame_overlay_mixer #(.blink_frames(2), .flash_frames(3)) dut_a (
    .clk(clk), .rst(rst), .display_on(display_on), .x(x), .y(y),
    .game_rgb(game_rgb), .frame_en(frame_en), .blink_en(blink_en),
    .flash_req(flash_req), .red(red_a), .green(green_a), .blue(blue_a),
    .frame_tick(frame_tick_a), .flashing(flashing_a)
  );

  // Instance B: three-pixel border.
  frame_overlay_mixer #(.thickness(3)) dut_b (
    .clk(clk), .rst(rst), .display_on(display_on), .x(x), .y(y),
    .game_rgb(game_rgb), .frame_en(frame_en), .blink_en(blink_en),
    .flash_req(flash_req), .red(red_b), .green(green_b), .blue(blue_b),
    .frame_tick(frame_tick_b), .flashing(flashing_b)
  );

  function automatic logic [11:0] ex(input logic [2:0] c);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  function automatic vec_t mk(input logic d, input int px, input int py,
                              input logic [2:0] g, input logic f,
                              input logic [2:0] ea, input logic [2:0] eb);
    vec_t v;
    v.disp  = d;
    v.px    = px[9:0];
    v.py    = py[8:0];
    v.rgb   = g;
    v.fen   = f;
    v.exp_a = ea;
    v.exp_b = eb;
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One frame: origin held two cycles, a mid-frame pixel, then a border probe.
  task automatic run_frame(input logic req_tick, input logic req_mid,
                           input logic exp_fl, input logic [2:0] exp_c,
                           input string tag);
    int ticks = 0;
    x = '0; y = '0; flash_req = req_tick;
    step; ticks += int'(frame_tick_a);
    flash_req = 1'b0;
    step; ticks += int'(frame_tick_a);
    x = 10'd10; y = 9'd10; flash_req = req_mid;
    step; ticks += int'(frame_tick_a);
    flash_req = 1'b0; x = 10'd213; y = 9'd100;
    step;
    total_ticks += ticks;
    chk({tag, " ticks"}, 12'(ticks), 12'd1);
    chk({tag, " flashing"}, 12'(flashing_a), 12'(exp_fl));
    chk({tag, " colour"}, {red_a, green_a, blue_a}, ex(exp_c));
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 213, 100, K, 1'b1, W, W);
    vecs[1]  = mk(1'b1, 212, 100, K, 1'b1, K, K);
    vecs[2]  = mk(1'b1, 214, 100, K, 1'b1, K, W);
    vecs[3]  = mk(1'b1, 215, 100, K, 1'b1, K, W);
    vecs[4]  = mk(1'b1, 216, 100, K, 1'b1, K, K);
    vecs[5]  = mk(1'b1, 422, 100, K, 1'b1, K, K);
    vecs[6]  = mk(1'b1, 423, 100, K, 1'b1, K, W);
    vecs[7]  = mk(1'b1, 425, 100, K, 1'b1, W, W);
    vecs[8]  = mk(1'b1, 426, 100, K, 1'b1, K, K);
    vecs[9]  = mk(1'b1, 300,   1, K, 1'b1, W, W);
    vecs[10] = mk(1'b1, 300,   0, K, 1'b1, K, K);
    vecs[11] = mk(1'b1, 300, 478, K, 1'b1, W, W);
    vecs[12] = mk(1'b1, 300, 479, K, 1'b1, K, K);
    vecs[13] = mk(1'b1, 300,   3, K, 1'b1, K, W);
    vecs[14] = mk(1'b1, 300,   4, K, 1'b1, K, K);
    vecs[15] = mk(1'b1, 213, 100, G, 1'b1, G, G);
    vecs[16] = mk(1'b0, 213, 100, W, 1'b1, K, K);
    vecs[17] = mk(1'b1, 213, 100, K, 1'b0, K, K);
    vecs[18] = mk(1'b1,  50,  50, M, 1'b1, M, M);

    // Reset held at the origin with an opaque game pixel on the inputs.
    rst = 1'b1; display_on = 1'b1; frame_en = 1'b1; game_rgb = W; x = '0; y = '0;
    step; step; step;
    chk("reset colour a", {red_a, green_a, blue_a}, 12'h000);
    chk("reset colour b", {red_b, green_b, blue_b}, 12'h000);
    chk("reset tick/flash", {8'h00, frame_tick_a, flashing_a, frame_tick_b, flashing_b}, 12'h000);

    // Releasing reset at the origin must not produce a tick.
    rst = 1'b0; game_rgb = K;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("no tick after reset %0d", i), 12'({frame_tick_a, frame_tick_b}), 12'd0);
    end

    foreach (vecs[i]) begin
      display_on = vecs[i].disp; x = vecs[i].px; y = vecs[i].py;
      game_rgb = vecs[i].rgb; frame_en = vecs[i].fen;
      step;
      chk($sformatf("vec%0d a", i), {red_a, green_a, blue_a}, ex(vecs[i].exp_a));
      chk($sformatf("vec%0d b", i), {red_b, green_b, blue_b}, ex(vecs[i].exp_b));
    end

    // Row sweeps of the static border: top, bottom, interior and outside rows.
    display_on = 1'b1; frame_en = 1'b1; game_rgb = K;
    begin
      int rows[5] = '{0, 1, 100, 478, 479};
      foreach (rows[j]) begin
        for (int xx = 0; xx < 640; xx++) begin
          logic on;
          x = 10'(xx); y = 9'(rows[j]);
          step;
          on = (rows[j] >= 1) && (rows[j] < 479) &&
               ((xx == 213) || (xx == 425) ||
                (((rows[j] == 1) || (rows[j] == 478)) && (xx >= 213) && (xx < 426)));
          chk($sformatf("sweep x=%0d y=%0d", xx, rows[j]), {red_a, green_a, blue_a},
              on ? ex(W) : ex(K));
        end
      end
    end

    // Blink: two-frame half period starting from visible.
    x = 10'd10; y = 9'd10; blink_en = 1'b1;
    step;
    total_ticks = 0;
    run_frame(1'b0, 1'b0, 1'b0, W, "blink f1");
    run_frame(1'b0, 1'b0, 1'b0, K, "blink f2");
    run_frame(1'b0, 1'b0, 1'b0, K, "blink f3");
    run_frame(1'b0, 1'b0, 1'b0, W, "blink f4");
    run_frame(1'b0, 1'b0, 1'b0, W, "blink f5");
    run_frame(1'b0, 1'b0, 1'b0, K, "blink f6");
    chk("blink total ticks", 12'(total_ticks), 12'd6);

    // Flash for three frames, retriggered in flash frame 2.
    run_frame(1'b0, 1'b1, 1'b1, R, "flash f0");
    run_frame(1'b0, 1'b0, 1'b1, R, "flash f1");
    run_frame(1'b0, 1'b1, 1'b1, R, "flash f2");
    run_frame(1'b0, 1'b0, 1'b1, R, "flash f3");
    run_frame(1'b0, 1'b0, 1'b1, R, "flash f4");
    run_frame(1'b0, 1'b0, 1'b0, W, "flash f5");

    // Request coinciding with the final tick keeps the flash alive.
    run_frame(1'b0, 1'b1, 1'b1, R, "coinc f0");
    run_frame(1'b0, 1'b0, 1'b1, R, "coinc f1");
    run_frame(1'b0, 1'b0, 1'b1, R, "coinc f2");
    run_frame(1'b1, 1'b0, 1'b1, R, "coinc f3");
    run_frame(1'b0, 1'b0, 1'b1, R, "coinc f4");
    run_frame(1'b0, 1'b0, 1'b1, R, "coinc f5");
    run_frame(1'b0, 1'b0, 1'b0, K, "coinc f6");

    // Reset in the middle of a flash.
    run_frame(1'b0, 1'b1, 1'b1, R, "rst flash");
    rst = 1'b1; x = 10'd213; y = 9'd100;
    step;
    chk("mid-flash reset flashing", 12'(flashing_a), 12'd0);
    chk("mid-flash reset colour", {red_a, green_a, blue_a}, 12'h000);
    rst = 1'b0;
    step;
    chk("after reset border", {red_a, green_a, blue_a}, ex(W));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
